// File: rtl/ranc_core_pkg.sv
// Shared types and constants for the RANC core scan path.
// Axon counts, index-width helper and scan FSM encoding.
package ranc_core_pkg;

  localparam int NUM_AXONS_DEF = 256;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

  function automatic int AXON_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/con_result_fifo.sv
// Small tag FIFO holding connected axon indices
// until the integrate stage accepts them.
module con_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;
  logic          do_push;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  // A simultaneous pop frees the slot this push needs.
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= inc(wr_q);
      end
      if (do_pop) rd_q <= inc(rd_q);
      if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign valid_o = cnt_q != '0;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/axon_scan_ctrl.sv
// Per-tick axon scan: walks latched spikes, issues connection
// lookups under credit, forwards connected axons in order.
module axon_scan_ctrl
  import ranc_core_pkg::*;
#(
  parameter int NUM_AXONS   = NUM_AXONS_DEF,
  parameter int CON_LATENCY = 1,
  parameter int RES_DEPTH   = 2,
  localparam int AW         = AXON_W(NUM_AXONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NUM_AXONS-1:0] spike_vec,
  output logic [AW-1:0]        axon_number,
  input  logic                 connection,
  output logic                 int_valid,
  output logic [AW-1:0]        int_axon,
  input  logic                 int_ready,
  output logic                 busy,
  output logic                 scan_done,
  output logic                 tick_overrun
);

  localparam int CW = $clog2(RES_DEPTH + 1);

  scan_state_e            state_q;
  logic [AW-1:0]          ptr_q;
  logic [NUM_AXONS-1:0]   spk_q;
  logic [CON_LATENCY-1:0] infl_v_q;
  logic [AW-1:0]          infl_tag_q [CON_LATENCY];

  logic [CW-1:0] buf_cnt;
  logic          buf_valid;
  logic [AW-1:0] buf_head;
  logic          in_scan;
  logic          cur_spk;
  logic          credit_ok;
  logic          issue;
  logic          advance;
  logic          at_last;
  logic          push;
  int            inflight;

  assign in_scan   = state_q == S_SCAN;
  assign cur_spk   = spk_q[ptr_q];
  assign inflight  = $countones(infl_v_q);
  // Reserve a buffer slot for every lookup still in flight.
  assign credit_ok = (int'(buf_cnt) + inflight) < RES_DEPTH;
  assign issue     = in_scan && cur_spk && credit_ok;
  assign advance   = in_scan && (!cur_spk || credit_ok);
  assign at_last   = ptr_q == AW'(NUM_AXONS - 1);
  assign push      = infl_v_q[CON_LATENCY-1] && connection;

  con_result_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (AW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (infl_tag_q[CON_LATENCY-1]),
    .pop_i   (int_ready),
    .valid_o (buf_valid),
    .data_o  (buf_head),
    .count_o (buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      spk_q    <= '0;
      infl_v_q <= '0;
      for (int i = 0; i < CON_LATENCY; i++) infl_tag_q[i] <= '0;
    end else begin
      infl_v_q[0]   <= issue;
      infl_tag_q[0] <= ptr_q;
      for (int i = 1; i < CON_LATENCY; i++) begin
        infl_v_q[i]   <= infl_v_q[i-1];
        infl_tag_q[i] <= infl_tag_q[i-1];
      end
      unique case (state_q)
        S_IDLE: begin
          if (tick) begin
            spk_q   <= spike_vec;
            ptr_q   <= '0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (advance) begin
            if (at_last) state_q <= S_DRAIN;
            else ptr_q <= ptr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (inflight == 0 && buf_cnt == '0) state_q <= S_DONE;
        end
        S_DONE: begin
          ptr_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign axon_number  = in_scan ? ptr_q : '0;
  assign int_valid    = buf_valid;
  assign int_axon     = buf_head;
  assign busy         = state_q != S_IDLE;
  assign scan_done    = state_q == S_DONE;
  assign tick_overrun = tick && busy && !rst;

endmodule

// File: tb/tb_axon_scan_ctrl.sv
// Bench for axon_scan_ctrl: timing table, corner sequences
// and random scans against an ordered-list reference model.
module tb_axon_scan_ctrl;

  localparam int N  = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [N-1:0]  spike_vec = '0;
  logic [AW-1:0] axon_number;
  logic          connection = 1'b0;
  logic          int_valid;
  logic [AW-1:0] int_axon;
  logic          int_ready = 1'b0;
  logic          busy;
  logic          scan_done;
  logic          tick_overrun;

  always #5 clk = ~clk;

  axon_scan_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .spike_vec    (spike_vec),
    .axon_number  (axon_number),
    .connection   (connection),
    .int_valid    (int_valid),
    .int_axon     (int_axon),
    .int_ready    (int_ready),
    .busy         (busy),
    .scan_done    (scan_done),
    .tick_overrun (tick_overrun)
  );

  logic [N-1:0] conn_map = '0;
  always @(posedge clk) connection <= conn_map[axon_number];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rmode = 0;
  int t0 = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: int_ready = 1'b1;
      1: int_ready = ~int_ready;
      2: int_ready = (cyc >= t0 + 20);
      3: int_ready = 1'($urandom_range(0, 1));
      default: int_ready = 1'b0;
    endcase
  end

  int got_q[$];
  int got_c[$];
  int done_n, done_c, ovr_n, ovr_c, busy_n;
  int total = 0;
  int bad = 0;
  int T;

  always @(negedge clk) begin
    if (!rst) begin
      if (int_valid && int_ready) begin
        got_q.push_back(int'(int_axon));
        got_c.push_back(cyc);
      end
      if (scan_done) begin done_n++; done_c = cyc; end
      if (tick_overrun) begin ovr_n++; ovr_c = cyc; end
      if (busy) busy_n++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_c.delete();
    done_n = 0; done_c = 0; ovr_n = 0; ovr_c = 0; busy_n = 0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic start_scan(input logic [N-1:0] spk, input int mode);
    clear_mon();
    rmode = mode;
    t0 = cyc;
    T = cyc;
    spike_vec = spk;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    spike_vec = ~spk;
  endtask

  task automatic wait_done();
    int lim;
    lim = cyc + 2000;
    while (done_n == 0 && cyc < lim) begin @(posedge clk); #1; end
    repeat (4) @(posedge clk);
    #1;
    check("done_once", done_n, 1);
  endtask

  task automatic check_seq(input logic [N-1:0] spk, input string nm);
    int exp_q[$];
    int fb;
    int mx;
    for (int i = 0; i < N; i++) if (spk[i] && conn_map[i]) exp_q.push_back(i);
    fb = -1;
    mx = (exp_q.size() > got_q.size()) ? exp_q.size() : got_q.size();
    for (int i = 0; i < mx; i++) begin
      if (i >= got_q.size() || i >= exp_q.size() || got_q[i] != exp_q[i]) begin
        fb = i;
        break;
      end
    end
    check({nm, "_first_bad_idx"}, fb, -1);
  endtask

  typedef struct {
    int a;
    bit c;
    int nreq;
    int vcyc;
    int dcyc;
  } vec_t;

  vec_t tbl[8];
  logic [N-1:0] spk;

  initial begin
    tbl[0] = '{-1,  1'b0, 0, 0,   258};
    tbl[1] = '{5,   1'b1, 1, 8,   258};
    tbl[2] = '{6,   1'b0, 0, 0,   258};
    tbl[3] = '{0,   1'b1, 1, 3,   258};
    tbl[4] = '{253, 1'b1, 1, 256, 258};
    tbl[5] = '{254, 1'b1, 1, 257, 259};
    tbl[6] = '{255, 1'b1, 1, 258, 260};
    tbl[7] = '{255, 1'b0, 0, 0,   259};

    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_axon_number", int'(axon_number), 0);
    check("rst_int_valid", int'(int_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_scan_done", int'(scan_done), 0);
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      conn_map = '0;
      spk = '0;
      if (tbl[k].a >= 0) begin
        spk[tbl[k].a] = 1'b1;
        conn_map[tbl[k].a] = tbl[k].c;
      end
      start_scan(spk, 0);
      wait_done();
      check($sformatf("t%0d_nreq", k), got_q.size(), tbl[k].nreq);
      if (got_q.size() > 0 && tbl[k].nreq > 0) begin
        check($sformatf("t%0d_axon", k), got_q[0], tbl[k].a);
        check($sformatf("t%0d_vcyc", k), got_c[0] - T, tbl[k].vcyc);
      end
      check($sformatf("t%0d_done_cyc", k), done_c - T, tbl[k].dcyc);
      check($sformatf("t%0d_busy_cycles", k), busy_n, tbl[k].dcyc);
    end

    // backpressure: buffer fills with {0,1}, scan holds on axon 2
    conn_map = '1;
    spk = '0;
    spk[0] = 1'b1; spk[1] = 1'b1; spk[2] = 1'b1; spk[255] = 1'b1;
    start_scan(spk, 2);
    wait_cyc(T + 10);
    @(negedge clk);
    check("bp_axon_number", int'(axon_number), 2);
    check("bp_int_valid", int'(int_valid), 1);
    check("bp_int_axon", int'(int_axon), 0);
    wait_done();
    check_seq(spk, "bp_seq");

    // overrun tick mid-scan is ignored apart from the pulse
    spk = '0;
    spk[3] = 1'b1; spk[100] = 1'b1;
    start_scan(spk, 0);
    wait_cyc(T + 50);
    tick = 1'b1;
    spike_vec = '1;
    @(posedge clk); #1;
    tick = 1'b0;
    wait_done();
    check("ovr_count", ovr_n, 1);
    check("ovr_cyc", ovr_c - T, 50);
    check("ovr_done_cyc", done_c - T, 258);
    check_seq(spk, "ovr_seq");

    // reset mid-scan with a result pending
    spk = '0;
    spk[5] = 1'b1; spk[10] = 1'b1;
    start_scan(spk, 4);
    wait_cyc(T + 30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rmode = 0;
    @(negedge clk);
    check("mrst_axon_number", int'(axon_number), 0);
    check("mrst_int_valid", int'(int_valid), 0);
    check("mrst_int_axon", int'(int_axon), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_scan_done", int'(scan_done), 0);
    check("mrst_overrun", int'(tick_overrun), 0);
    clear_mon();
    repeat (300) @(posedge clk);
    #1;
    check("mrst_no_done", done_n, 0);
    check("mrst_no_req", got_q.size(), 0);
    check("mrst_idle", busy_n, 0);

    // all spiking and connected, ready toggling
    spk = '1;
    conn_map = '1;
    start_scan(spk, 1);
    wait_done();
    check("full_nreq", got_q.size(), 256);
    check_seq(spk, "full_seq");

    for (int k = 0; k < 6; k++) begin
      conn_map = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < N; i++) spk[i] = ($urandom_range(0, 2) == 0);
      start_scan(spk, 3);
      wait_done();
      check_seq(spk, $sformatf("rnd%0d_seq", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
